pattern_det_ctrl: RTL and testbench

- Run controller for a programmable serial sequence detector, the configurable successor of the fixed "010" detector FSMs in the sequential library.
- Holds the pattern configuration and arms/disarms detection under start/stop commands.
- Limits detection to an optional sample window, counts matches with saturation, and flags a programmable match threshold.
- Sits between a control/CSR front end and a serial bit stream with a valid qualifier.

---
 rtl/seq_pkg.sv | 7 +
 rtl/pattern_matcher.sv | 41 ++++
 rtl/pattern_det_ctrl.sv | 105 ++++++++++
 tb/tb_pattern_det_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and field widths for the sequence detector
package seq_pkg;
    localparam int LEN_W = 4;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/pattern_matcher.sv
// pattern_matcher: sample shift register, fill counter and masked pattern compare
module pattern_matcher
    import seq_pkg::*;
#(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             x,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);
    logic [PAT_W-1:0] shift_q, shift_d, shifted, mask;
    logic [LEN_W-1:0] fill_q, fill_d, fill_inc;

    // match is judged on the value the shift register takes at this edge
    always_comb begin
        shifted  = {shift_q[PAT_W-2:0], x};
        mask     = '0;
        for (int i = 0; i < PAT_W; i++) mask[i] = i < int'(len);
        fill_inc = (fill_q < len) ? fill_q + LEN_W'(1) : fill_q;
        match    = shift_en && fill_inc == len && ((shifted ^ pattern) & mask) == '0;
        shift_d  = clr ? '0 : shift_en ? shifted : shift_q;
        fill_d   = clr ? '0 : !shift_en ? fill_q : (match && !overlap) ? '0 : fill_inc;
    end

    // sample history and fill state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            fill_q  <= '0;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
        end
    end
endmodule

// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: run controller for a programmable serial sequence detector
module pattern_det_ctrl
    import seq_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 10,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             start,
    input  logic             stop,
    input  logic             clr_cnt,
    input  logic             x,
    input  logic             x_valid,
    output logic             busy,
    output logic             y,
    output logic [CNT_W-1:0] count,
    output logic             thresh_hit,
    output logic             done,
    output logic             cfg_err
);
    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] thresh_q;
    logic [WIN_W-1:0] window_q, win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             thr_q, thr_d, y_q, err_q, err_d;
    logic             run, len_ok, start_ok, shift_en, win_end, ld, match;

    pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .shift_en(shift_en),
        .x       (x),
        .len     (len_q),
        .pattern (pattern_q),
        .overlap (overlap_q),
        .match   (match)
    );

    // command decode, window tracking and saturating match count
    always_comb begin
        run      = state_q == RUN;
        len_ok   = len_q >= LEN_W'(2) && len_q <= LEN_W'(PAT_W);
        start_ok = start && !stop && !run && len_ok;
        shift_en = run && x_valid && !stop;
        ld       = cfg_load && !run;
        win_end  = shift_en && window_q != '0 && win_q + WIN_W'(1) == window_q;
        state_d  = stop ? IDLE : start_ok ? RUN : win_end ? DONE : state_q;
        win_d    = start_ok ? '0 : shift_en ? win_q + WIN_W'(1) : win_q;
        cnt_inc  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        cnt_d    = (clr_cnt || start_ok) ? '0 : match ? cnt_inc : cnt_q;
        thr_d    = (clr_cnt || start_ok) ? 1'b0
                 : (match && thresh_q != '0 && cnt_inc == thresh_q && cnt_inc != cnt_q) ? 1'b1 : thr_q;
        err_d    = ((cfg_load && run) || (start && !stop && !run && !len_ok)) ? 1'b1 : ld ? 1'b0 : err_q;
    end

    // state, configuration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            thresh_q  <= '0;
            window_q  <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            thr_q     <= 1'b0;
            y_q       <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                thresh_q  <= cfg_thresh;
                window_q  <= cfg_window;
            end
            win_q <= win_d;
            cnt_q <= cnt_d;
            thr_q <= thr_d;
            y_q   <= match;
            err_q <= err_d;
        end
    end

    assign busy       = run;
    assign done       = state_q == DONE;
    assign y          = y_q;
    assign count      = cnt_q;
    assign thresh_hit = thr_q;
    assign cfg_err    = err_q;
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// tb_pattern_det_ctrl: directed self-checking bench for pattern_det_ctrl
module tb_pattern_det_ctrl;
    logic        clk, rst, cfg_load, cfg_overlap, start, stop, clr_cnt, x, x_valid;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [9:0]  cfg_thresh;
    logic [1:0]  s_thresh;
    logic [15:0] cfg_window;
    logic        busy, y, thresh_hit, done, cfg_err;
    logic [9:0]  count;
    logic        s_busy, s_y, s_thresh_hit, s_done, s_cfg_err;
    logic [1:0]  s_count;
    int checks = 0, failures = 0;

    pattern_det_ctrl dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh), .cfg_window(cfg_window), .start(start),
        .stop(stop), .clr_cnt(clr_cnt), .x(x), .x_valid(x_valid), .busy(busy), .y(y), .count(count),
        .thresh_hit(thresh_hit), .done(done), .cfg_err(cfg_err)
    );

    pattern_det_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_thresh(s_thresh), .cfg_window(cfg_window), .start(start),
        .stop(stop), .clr_cnt(clr_cnt), .x(x), .x_valid(x_valid), .busy(s_busy), .y(s_y), .count(s_count),
        .thresh_hit(s_thresh_hit), .done(s_done), .cfg_err(s_cfg_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [9:0] th, input logic [15:0] w);
        cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_thresh = th; cfg_window = w;
        cfg_load = 1; cyc(); cfg_load = 0;
    endtask

    task automatic go();
        start = 1; cyc(); start = 0;
    endtask

    task automatic halt();
        stop = 1; cyc(); stop = 0;
    endtask

    task automatic send(input logic b);
        x = b; x_valid = 1; cyc(); x_valid = 0;
    endtask

    task automatic test_reset();
        #2 rst = 1;
        #1;
        checks++;
        if ({busy, y, count, thresh_hit, done, cfg_err} !== '0) begin
            $display("FAIL reset_outputs got=%b exp=0", {busy, y, count, thresh_hit, done, cfg_err}); failures++;
        end
        cyc(); cyc();
        rst = 0;
        send(0);
        checks++;
        if (busy !== 0 || y !== 0) begin $display("FAIL reset_idle busy=%b y=%b exp 0 0", busy, y); failures++; end
    endtask

    task automatic test_overlap();
        logic [4:0] b, ey;
        b = 5'b01010; ey = 5'b10100;
        load(8'b010, 3, 1, 0, 0); go();
        checks++;
        if (busy !== 1 || count !== 0) begin $display("FAIL ov_start busy=%b count=%0d exp 1 0", busy, count); failures++; end
        for (int i = 0; i < 5; i++) begin
            send(b[i]);
            checks++;
            if (y !== ey[i] || busy !== 1) begin
                $display("FAIL ov_y[%0d] y=%b busy=%b exp y=%b busy=1", i, y, busy, ey[i]); failures++;
            end
        end
        checks++;
        if (count !== 2) begin $display("FAIL ov_count got=%0d exp=2", count); failures++; end
        cyc();
        checks++;
        if (y !== 0) begin $display("FAIL ov_y_idle got=%b exp=0", y); failures++; end
        halt();
        checks++;
        if (busy !== 0 || count !== 2) begin $display("FAIL ov_stop busy=%b count=%0d exp 0 2", busy, count); failures++; end
    endtask

    task automatic test_nonoverlap();
        logic [4:0] b, ey;
        b = 5'b01010; ey = 5'b00100;
        load(8'b010, 3, 0, 0, 0); go();
        for (int i = 0; i < 5; i++) begin
            send(b[i]);
            checks++;
            if (y !== ey[i]) begin $display("FAIL nov_y[%0d] got=%b exp=%b", i, y, ey[i]); failures++; end
        end
        checks++;
        if (count !== 1) begin $display("FAIL nov_count got=%0d exp=1", count); failures++; end
        halt();
    endtask

    task automatic test_window();
        logic [5:0] b, ey;
        b = 6'b010110; ey = 6'b001000;
        load(8'b110, 3, 1, 1, 4); go();
        for (int i = 0; i < 6; i++) begin
            send(b[i]);
            checks++;
            if (y !== ey[i] || done !== (i >= 3) || thresh_hit !== (i >= 3) || busy !== (i < 3)) begin
                $display("FAIL win[%0d] y=%b done=%b th=%b busy=%b exp y=%b done=%b th=%b busy=%b",
                         i, y, done, thresh_hit, busy, ey[i], i >= 3, i >= 3, i < 3);
                failures++;
            end
        end
        checks++;
        if (count !== 1) begin $display("FAIL win_count got=%0d exp=1", count); failures++; end
        halt();
        checks++;
        if (done !== 0 || busy !== 0 || count !== 1 || thresh_hit !== 1) begin
            $display("FAIL win_stop done=%b busy=%b count=%0d th=%b exp 0 0 1 1", done, busy, count, thresh_hit); failures++;
        end
    endtask

    task automatic test_saturation();
        int k;
        load(8'b01, 2, 1, 0, 0); go();
        k = 0;
        for (int i = 0; i < 10; i++) begin
            send(i[0]);
            if (i[0]) k++;
            checks++;
            if (s_y !== i[0] || int'(s_count) !== (k > 3 ? 3 : k)) begin
                $display("FAIL sat[%0d] y=%b count=%0d exp y=%b count=%0d", i, s_y, s_count, i[0], k > 3 ? 3 : k);
                failures++;
            end
        end
        checks++;
        if (count !== 5) begin $display("FAIL sat_wide_count got=%0d exp=5", count); failures++; end
        halt();
    endtask

    task automatic test_errors();
        load(8'b010, 3, 1, 0, 0); go();
        cfg_pattern = 8'hFF; cfg_len = 2; cfg_load = 1; cyc(); cfg_load = 0;
        checks++;
        if (cfg_err !== 1 || busy !== 1) begin $display("FAIL err_load_run err=%b busy=%b exp 1 1", cfg_err, busy); failures++; end
        send(0); send(1); send(0);
        checks++;
        if (y !== 1) begin $display("FAIL err_cfg_kept y=%b exp=1", y); failures++; end
        halt();
        load(8'b010, 1, 1, 0, 0);
        checks++;
        if (cfg_err !== 0) begin $display("FAIL err_load_clears got=%b exp=0", cfg_err); failures++; end
        go();
        checks++;
        if (busy !== 0 || cfg_err !== 1) begin $display("FAIL err_bad_len busy=%b err=%b exp 0 1", busy, cfg_err); failures++; end
        load(8'b010, 3, 1, 0, 0);
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        checks++;
        if (busy !== 0 || cfg_err !== 0) begin $display("FAIL err_start_stop busy=%b err=%b exp 0 0", busy, cfg_err); failures++; end
        load(8'b010, 3, 1, 1, 0); go();
        send(0); send(1); send(0);
        checks++;
        if (count !== 1 || thresh_hit !== 1) begin $display("FAIL clr_pre count=%0d th=%b exp 1 1", count, thresh_hit); failures++; end
        send(1);
        x = 0; x_valid = 1; clr_cnt = 1; cyc(); x_valid = 0; clr_cnt = 0;
        checks++;
        if (y !== 1 || count !== 0 || thresh_hit !== 0) begin
            $display("FAIL clr_match y=%b count=%0d th=%b exp 1 0 0", y, count, thresh_hit); failures++;
        end
        halt();
    endtask

    task automatic test_reset_midrun();
        logic [6:0] b;
        b = 7'b0101010;
        load(8'b010, 3, 1, 2, 0); go();
        cfg_load = 1; cyc(); cfg_load = 0;
        for (int i = 0; i < 7; i++) send(b[i]);
        checks++;
        if (count !== 3 || thresh_hit !== 1 || y !== 1 || cfg_err !== 1 || busy !== 1) begin
            $display("FAIL rst_pre count=%0d th=%b y=%b err=%b busy=%b exp 3 1 1 1 1", count, thresh_hit, y, cfg_err, busy);
            failures++;
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({busy, y, count, thresh_hit, done, cfg_err} !== '0) begin
            $display("FAIL rst_async got=%b exp=0", {busy, y, count, thresh_hit, done, cfg_err}); failures++;
        end
        @(posedge clk); #1 rst = 0;
        send(0); send(1); send(0);
        checks++;
        if (y !== 0 || count !== 0 || busy !== 0) begin $display("FAIL rst_ignore y=%b count=%0d busy=%b exp 0 0 0", y, count, busy); failures++; end
        go();
        checks++;
        if (busy !== 0 || cfg_err !== 1) begin $display("FAIL rst_cfg_cleared busy=%b err=%b exp 0 1", busy, cfg_err); failures++; end
    endtask

    initial begin
        rst = 0; cfg_load = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_thresh = 0; s_thresh = 0;
        cfg_window = 0; start = 0; stop = 0; clr_cnt = 0; x = 0; x_valid = 0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_window();
        test_saturation();
        test_errors();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
